// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates ALU and LSB results onto the single common data bus.
// Each source has its own DEPTH-entry circular FIFO; one registered broadcast
// per cycle is chosen round-robin.
// Optional feature macro: CDB_BYPASS_EN. When defined, a result arriving at an
// empty FIFO can be granted in the same cycle and go straight to the CDB
// registers. This gives a minimum latency of 1 cycle instead of 2.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int RB_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu_flag,
    input  logic [RB_W-1:0]   alu_reorder,
    input  logic [DATA_W-1:0] alu_val,
    input  logic [5:0]        alu_opcode,
    input  logic              lsb_flag,
    input  logic [RB_W-1:0]   lsb_reorder,
    input  logic [5:0]        lsb_op,
    input  logic [DATA_W-1:0] lsb_val,
    output logic              alu_full,
    output logic              lsb_full,
    output logic              cdb_flag,
    output logic [RB_W-1:0]   cdb_reorder,
    output logic [DATA_W-1:0] cdb_val,
    output logic [5:0]        cdb_op,
    output logic              cdb_src,
    output logic              ovf_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = RB_W + DATA_W + 6;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Index 0 is the ALU source and index 1 is the LSB source; the same
    // numbering is used for cdb_src.
    logic [1:0]       in_flag;
    logic [ENT_W-1:0] in_ent   [2];
    logic [ENT_W-1:0] head_ent [2];
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       bypass_take;
    logic [1:0]       push_en;
    logic [1:0]       pop_en;
    logic [1:0]       ovf_hit;
    logic [ENT_W-1:0] sel_ent;
    logic             last_grant_reg;
    logic             advance;

    logic              cdb_flag_reg;
    logic [RB_W-1:0]   cdb_reorder_reg;
    logic [DATA_W-1:0] cdb_val_reg;
    logic [5:0]        cdb_op_reg;
    logic              cdb_src_reg;
    logic              ovf_err_reg;

    assign in_flag   = {lsb_flag, alu_flag};
    assign in_ent[0] = {alu_reorder, alu_val, alu_opcode};
    assign in_ent[1] = {lsb_reorder, lsb_val, lsb_op};

    // FIFO state may change only on a ready, non-flush cycle.
    assign advance = rdy & ~flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [CNT_W-1:0] cnt_reg;

            assign full[gi]     = (cnt_reg == DEPTH_CNT);
            assign empty[gi]    = (cnt_reg == '0);
            assign head_ent[gi] = mem[rd_ptr_reg];
`ifdef CDB_BYPASS_EN
            assign eligible[gi]    = ~empty[gi] | in_flag[gi];
            assign bypass_take[gi] = grant[gi] & empty[gi];
`else
            assign eligible[gi]    = ~empty[gi];
            assign bypass_take[gi] = 1'b0;
`endif
            assign pop_en[gi] = grant[gi] & ~empty[gi];
            // A bypassed result is already on its way to the CDB.
            // Storing it as well would broadcast it twice.
            assign push_en[gi] = in_flag[gi] & ~full[gi] & ~bypass_take[gi];
            // Fullness is taken from the count at the start of the cycle.
            // A pop in the same cycle does not free a slot for the push.
            assign ovf_hit[gi] = in_flag[gi] & full[gi];

            // Pointer and count bookkeeping. Flush empties the FIFO.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else if (rdy) begin
                    if (flush) begin
                        rd_ptr_reg <= '0;
                        wr_ptr_reg <= '0;
                        cnt_reg    <= '0;
                    end else begin
                        if (push_en[gi]) begin
                            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        end
                        if (pop_en[gi]) begin
                            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                        end
                        cnt_reg <= cnt_reg + CNT_W'(push_en[gi]) - CNT_W'(pop_en[gi]);
                    end
                end
            end

            // Entry storage. It has no reset because the count defines which slots are valid.
            always_ff @(posedge clk) begin
                if (rst && advance && push_en[gi]) begin
                    mem[wr_ptr_reg] <= in_ent[gi];
                end
            end
        end
    endgenerate

    // Round-robin arbitration. On a tie, the source not granted last time wins.
    always_comb begin
        grant = eligible;
        if (eligible[0] && eligible[1]) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    // Pick the winning entry: the FIFO head, or the live inputs when bypassing.
    always_comb begin
        sel_ent = head_ent[0];
        if (grant[1]) begin
            sel_ent = bypass_take[1] ? in_ent[1] : head_ent[1];
        end else begin
            sel_ent = bypass_take[0] ? in_ent[0] : head_ent[0];
        end
    end

    // Registered CDB broadcast, grant history and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_flag_reg    <= 1'b0;
            cdb_reorder_reg <= '0;
            cdb_val_reg     <= '0;
            cdb_op_reg      <= '0;
            cdb_src_reg     <= 1'b0;
            ovf_err_reg     <= 1'b0;
            last_grant_reg  <= 1'b1;
        end else if (rdy) begin
            if (flush) begin
                cdb_flag_reg <= 1'b0;
            end else begin
                cdb_flag_reg <= |grant;
                if (|grant) begin
                    cdb_reorder_reg <= sel_ent[ENT_W-1 -: RB_W];
                    cdb_val_reg     <= sel_ent[6 +: DATA_W];
                    cdb_op_reg      <= sel_ent[5:0];
                    cdb_src_reg     <= grant[1];
                    last_grant_reg  <= grant[1];
                end
                if (|ovf_hit) begin
                    ovf_err_reg <= 1'b1;
                end
            end
        end
    end

    assign alu_full    = full[0];
    assign lsb_full    = full[1];
    assign cdb_flag    = cdb_flag_reg;
    assign cdb_reorder = cdb_reorder_reg;
    assign cdb_val     = cdb_val_reg;
    assign cdb_op      = cdb_op_reg;
    assign cdb_src     = cdb_src_reg;
    assign ovf_err     = ovf_err_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter. A queue-based reference model predicts every
// output after each clock edge. A compare process checks the DUT against the
// model on each falling edge, and directed scenarios add literal expectations.
// The model follows CDB_BYPASS_EN in the same way as the design.
module tb_cdb_arbiter;
    localparam int DEPTH  = 2;
    localparam int RB_W   = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
    logic              flush = 1'b0;
    logic              alu_flag = 1'b0;
    logic [RB_W-1:0]   alu_reorder = '0;
    logic [DATA_W-1:0] alu_val = '0;
    logic [5:0]        alu_opcode = '0;
    logic              lsb_flag = 1'b0;
    logic [RB_W-1:0]   lsb_reorder = '0;
    logic [5:0]        lsb_op = '0;
    logic [DATA_W-1:0] lsb_val = '0;
    logic              alu_full, lsb_full, cdb_flag, cdb_src, ovf_err;
    logic [RB_W-1:0]   cdb_reorder;
    logic [DATA_W-1:0] cdb_val;
    logic [5:0]        cdb_op;

    cdb_arbiter #(.DEPTH(DEPTH), .RB_W(RB_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_flag(alu_flag), .alu_reorder(alu_reorder), .alu_val(alu_val), .alu_opcode(alu_opcode),
        .lsb_flag(lsb_flag), .lsb_reorder(lsb_reorder), .lsb_op(lsb_op), .lsb_val(lsb_val),
        .alu_full(alu_full), .lsb_full(lsb_full), .cdb_flag(cdb_flag), .cdb_reorder(cdb_reorder),
        .cdb_val(cdb_val), .cdb_op(cdb_op), .cdb_src(cdb_src), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RB_W-1:0]   r;
        logic [DATA_W-1:0] v;
        logic [5:0]        op;
    } ent_t;

    ent_t              aq[$];
    ent_t              lq[$];
    logic              e_flag = 0, e_src = 0, e_ovf = 0, lg = 1;
    logic [RB_W-1:0]   e_r = '0;
    logic [DATA_W-1:0] e_v = '0;
    logic [5:0]        e_op = '0;
    int                mbc_a = 0, mbc_l = 0;
    int                checks = 0, errors = 0;
    bit                check_en = 0;
    int                a0, l0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance one clock edge using the current tb-driven inputs.
    task automatic model_step();
        int   na, nl;
        bit   ea, el, ga, gl, ab, lb;
        ent_t w;
        w = '0;
        if (!rst) begin
            aq.delete(); lq.delete();
            e_flag = 0; e_r = '0; e_v = '0; e_op = '0; e_src = 0; e_ovf = 0; lg = 1;
        end else if (rdy) begin
            if (flush) begin
                aq.delete(); lq.delete();
                e_flag = 0;
            end else begin
                na = aq.size(); nl = lq.size();
                ea = (na > 0); el = (nl > 0);
`ifdef CDB_BYPASS_EN
                ea = ea || alu_flag;
                el = el || lsb_flag;
`endif
                if (ea && el) begin ga = lg; gl = !lg; end
                else begin ga = ea; gl = el; end
                ab = 0; lb = 0;
                if (ga) begin
                    if (na > 0) w = aq.pop_front();
                    else begin w = {alu_reorder, alu_val, alu_opcode}; ab = 1; end
                    e_src = 0; lg = 0; mbc_a++;
                end else if (gl) begin
                    if (nl > 0) w = lq.pop_front();
                    else begin w = {lsb_reorder, lsb_val, lsb_op}; lb = 1; end
                    e_src = 1; lg = 1; mbc_l++;
                end
                e_flag = ga || gl;
                if (e_flag) begin e_r = w.r; e_v = w.v; e_op = w.op; end
                if (alu_flag) begin
                    if (na >= DEPTH) e_ovf = 1;
                    else if (!ab) aq.push_back({alu_reorder, alu_val, alu_opcode});
                end
                if (lsb_flag) begin
                    if (nl >= DEPTH) e_ovf = 1;
                    else if (!lb) lq.push_back({lsb_reorder, lsb_val, lsb_op});
                end
            end
        end
    endtask

    // Compare the DUT with the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cdb_flag", cdb_flag, e_flag);
            chk("cdb_reorder", cdb_reorder, e_r);
            chk("cdb_val", cdb_val, e_v);
            chk("cdb_op", cdb_op, e_op);
            chk("cdb_src", cdb_src, e_src);
            chk("ovf_err", ovf_err, e_ovf);
            chk("alu_full", alu_full, aq.size() == DEPTH);
            chk("lsb_full", lsb_full, lq.size() == DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        alu_flag = 0; lsb_flag = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 0; tick(); rst = 1;
    endtask

    task automatic push_alu(input int r, input int v);
        alu_flag = 1; alu_reorder = RB_W'(r); alu_val = DATA_W'(v); alu_opcode = 6'(r + 1);
    endtask

    task automatic push_lsb(input int r, input int v);
        lsb_flag = 1; lsb_reorder = RB_W'(r); lsb_val = DATA_W'(v); lsb_op = 6'(r + 2);
    endtask

    initial begin
        // Reset state
        rst = 0; rdy = 1;
        tick(); check_en = 1; tick();
        chk("rst_flag", cdb_flag, 0); chk("rst_ovf", ovf_err, 0);
        chk("rst_afull", alu_full, 0); chk("rst_lfull", lsb_full, 0);
        chk("rst_val", cdb_val, 0); chk("rst_src", cdb_src, 0);
        rst = 1;
        $display("reset done");

        // Single ALU result: latency is 2 cycles, or 1 with bypass.
        push_alu(3, 32'h12345678); tick();
`ifndef CDB_BYPASS_EN
        chk("t1_early", cdb_flag, 0); tick();
`endif
        chk("t1_flag", cdb_flag, 1); chk("t1_id", cdb_reorder, 3);
        chk("t1_val", cdb_val, 32'h12345678); chk("t1_src", cdb_src, 0);
        tick(); chk("t1_once", cdb_flag, 0);
        $display("single result: id=%0d val=%h", 3, 32'h12345678);

        // Same-cycle collision: ALU first, then LSB.
        do_reset();
        push_alu(5, 32'hA); push_lsb(6, 32'hB); tick();
`ifndef CDB_BYPASS_EN
        tick();
`endif
        chk("t2_first_flag", cdb_flag, 1); chk("t2_first_id", cdb_reorder, 5); chk("t2_first_src", cdb_src, 0);
        tick();
        chk("t2_second_flag", cdb_flag, 1); chk("t2_second_id", cdb_reorder, 6);
        chk("t2_second_src", cdb_src, 1); chk("t2_second_val", cdb_val, 32'hB);
        tick(); chk("t2_idle", cdb_flag, 0);
        $display("collision: ALU 5 then LSB 6");

        // Fairness: both sources push every other cycle, 8 results each.
        do_reset();
        a0 = mbc_a; l0 = mbc_l;
        for (int i = 0; i < 8; i++) begin
            push_alu(i, 32'h100 + i); push_lsb(8 + i, 32'h200 + i); tick();
            tick();
            $display("fairness pair %0d pushed", i);
        end
        for (int i = 0; i < 4; i++) tick();
        chk("t3_alu_count", mbc_a - a0, 8); chk("t3_lsb_count", mbc_l - l0, 8);
        chk("t3_ovf", ovf_err, 0); chk("t3_idle", cdb_flag, 0);

        // Overflow: LSB pushes 3 times in a row while the ALU competes.
        do_reset();
        l0 = mbc_l;
        push_alu(1, 32'h11); push_lsb(8, 32'h80); tick();
`ifndef CDB_BYPASS_EN
        chk("t4_lfull_1", lsb_full, 0);
`endif
        push_alu(2, 32'h22); push_lsb(9, 32'h90); tick();
`ifndef CDB_BYPASS_EN
        chk("t4_lfull_2", lsb_full, 1);
`endif
        push_alu(3, 32'h33); push_lsb(10, 32'hA0); tick();
`ifndef CDB_BYPASS_EN
        chk("t4_ovf", ovf_err, 1);
`endif
        for (int i = 0; i < 6; i++) tick();
`ifndef CDB_BYPASS_EN
        chk("t4_lsb_bcasts", mbc_l - l0, 2);
`endif
        $display("overflow sequence: ovf_err=%0d", ovf_err);

        // Flush with entries queued and a new push; ovf_err persists.
        push_alu(1, 32'h1); push_lsb(9, 32'h9); tick();
        push_alu(2, 32'h2); push_lsb(10, 32'hA); tick();
        a0 = mbc_a; l0 = mbc_l;
        flush = 1; push_alu(12, 32'hC); tick();
        chk("t5_flag", cdb_flag, 0); chk("t5_afull", alu_full, 0); chk("t5_lfull", lsb_full, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_alu", mbc_a - a0, 0); chk("t5_no_lsb", mbc_l - l0, 0);
        $display("flush: no broadcasts afterwards");

        // Stall: rdy low for 3 cycles while the LSB broadcast is pending.
        do_reset();
        push_alu(4, 32'h44); push_lsb(13, 32'hD0); tick();
        for (int k = 0; k < 4 && !cdb_flag; k++) tick();
        chk("t6_first_flag", cdb_flag, 1); chk("t6_first_id", cdb_reorder, 4);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            push_lsb(14, 32'hE0);
            tick();
            chk("t6_hold_flag", cdb_flag, 1); chk("t6_hold_id", cdb_reorder, 4); chk("t6_hold_src", cdb_src, 0);
            $display("stall cycle %0d", i);
        end
        rdy = 1; tick();
        chk("t6_resume_flag", cdb_flag, 1); chk("t6_resume_id", cdb_reorder, 13); chk("t6_resume_src", cdb_src, 1);
        tick(); chk("t6_after", cdb_flag, 0);

        // Reset mid-operation discards the queued entries.
        push_alu(7, 32'h77); push_lsb(15, 32'hF0); tick();
        rst = 0; tick();
        chk("t7_flag", cdb_flag, 0); chk("t7_id", cdb_reorder, 0); chk("t7_val", cdb_val, 0);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t7_empty", cdb_flag, 0);
        end
        $display("mid-operation reset: queues discarded");

        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
